ring_buffer_ovw: RTL and testbench

Parametrised successor ring buffer (FIFO) for the datapath buffering layer. It generalises width and depth, including non-power-of-two depths, and exposes an occupancy count, almost-full and almost-empty thresholds, and sticky overflow/underflow errors. A synthesis-time mode selects what happens on a write to a full buffer: reject it, or overwrite the oldest entry. A synchronous flush is also provided.

---
 rtl/ring_buffer_ovw.sv | 125 ++++++++++++
 tb/tb_ring_buffer_ovw.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_buffer_ovw.sv
// ring_buffer_ovw
//   Parametrised FIFO ring buffer with arbitrary (non power-of-two) depth,
//   occupancy count, almost-full/almost-empty thresholds, sticky
//   overflow/underflow errors, synchronous flush and an optional
//   overwrite-oldest mode for writes to a full buffer.
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   flush             synchronous clear of pointers and count
//   clr_err           synchronous clear of overflow/underflow (set wins)
//   wr_en, data_in    write request and data
//   rd_en             read request
//   data_out          registered read data, rd_valid pulses when updated
//   count             occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty   decoded from count
//   overflow, underflow                      sticky error flags
//   dropped           pulse: oldest entry discarded by an overwrite
module ring_buffer_ovw #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int OVERWRITE  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         clr_err,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam bit            OVW      = (OVERWRITE != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  logic is_full;
  logic is_empty;
  logic rd_acc;
  logic wr_acc;
  logic ovw_drop;
  logic wr_rej;
  logic rd_rej;

  // Explicit wrap at DEPTH-1 so non power-of-two depths stay in range.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    is_full  = (count == DEPTH_C);
    is_empty = (count == '0);
    rd_acc   = rd_en & ~flush & ~is_empty;
    // A full buffer still takes a write when a read frees a slot this cycle.
    wr_acc   = wr_en & ~flush & (~is_full | OVW | rd_acc);
    ovw_drop = wr_acc & is_full & ~rd_acc;
    wr_rej   = wr_en & ~flush & is_full & ~wr_acc;
    rd_rej   = rd_en & ~flush & is_empty;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      rd_valid  <= 1'b0;
      dropped   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      dropped  <= ovw_drop;

      if (rd_acc) data_out <= mem[rd_ptr];

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
        if (rd_acc || ovw_drop) rd_ptr <= next_ptr(rd_ptr);
        // An overwrite replaces an entry, so it does not change occupancy.
        case ({wr_acc & ~ovw_drop, rd_acc})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end

      if (wr_rej)       overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;

      if (rd_rej)       underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (int'(count) >= AF_LEVEL);
  assign almost_empty = (int'(count) <= AE_LEVEL);

endmodule

// File: tb/tb_ring_buffer_ovw.sv
module tb_ring_buffer_ovw;

  localparam int D = 5;
  localparam logic [18:0] RESET_V = {8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  typedef logic [7:0] q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, clr_err, wr_en, rd_en;
  logic [7:0] data_in;

  logic [7:0] d0, d1;
  logic [2:0] cnt0, cnt1;
  logic rv0, full0, empty0, af0, ae0, ovf0, unf0, drp0;
  logic rv1, full1, empty1, af1, ae1, ovf1, unf1, drp1;
  logic [18:0] v0, v1;

  assign v0 = {d0, rv0, cnt0, full0, empty0, af0, ae0, ovf0, unf0, drp0};
  assign v1 = {d1, rv1, cnt1, full1, empty1, af1, ae1, ovf1, unf1, drp1};

  ring_buffer_ovw #(.DATA_WIDTH(8), .DEPTH(D), .OVERWRITE(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .wr_en(wr_en),
    .data_in(data_in), .rd_en(rd_en), .data_out(d0), .rd_valid(rv0), .count(cnt0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .overflow(ovf0), .underflow(unf0), .dropped(drp0));

  ring_buffer_ovw #(.DATA_WIDTH(8), .DEPTH(D), .OVERWRITE(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .wr_en(wr_en),
    .data_in(data_in), .rd_en(rd_en), .data_out(d1), .rd_valid(rv1), .count(cnt1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .overflow(ovf1), .underflow(unf1), .dropped(drp1));

  // Reference model state: one queue per instance plus expected registers.
  q_t q0, q1;
  logic [7:0] ed0, ed1;
  bit erv0, erv1, edr0, edr1, eov0, eov1, eun0, eun1;

  int total = 0;
  int bad   = 0;

  task automatic model_step(input bit ovw, input bit w, input logic [7:0] d,
                            input bit r, input bit f, input bit ce,
                            inout q_t q, inout logic [7:0] dout, inout bit rv,
                            inout bit drop, inout bit ovf, inout bit unf);
    int n;
    n    = q.size();
    rv   = 1'b0;
    drop = 1'b0;
    if (ce) begin ovf = 1'b0; unf = 1'b0; end
    if (f) begin
      q.delete();
    end else begin
      if (r && n > 0) begin dout = q.pop_front(); rv = 1'b1; end
      if (r && n == 0) unf = 1'b1;
      if (w) begin
        if (n < D || rv) q.push_back(d);
        else if (ovw) begin void'(q.pop_front()); q.push_back(d); drop = 1'b1; end
        else ovf = 1'b1;
      end
    end
  endtask

  function automatic logic [18:0] exp_vec(input int n, input logic [7:0] d, input bit rv,
                                          input bit ovf, input bit unf, input bit drop);
    return {d, rv, 3'(n), n == D, n == 0, n >= D - 1, n <= 1, ovf, unf, drop};
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete();
    ed0 = '0; ed1 = '0;
    erv0 = 0; erv1 = 0; edr0 = 0; edr1 = 0; eov0 = 0; eov1 = 0; eun0 = 0; eun1 = 0;
  endtask

  task automatic cyc(input bit w, input logic [7:0] d, input bit r,
                     input bit f = 1'b0, input bit ce = 1'b0);
    @(negedge clk);
    wr_en = w; data_in = d; rd_en = r; flush = f; clr_err = ce;
    @(posedge clk);
    model_step(1'b0, w, d, r, f, ce, q0, ed0, erv0, edr0, eov0, eun0);
    model_step(1'b1, w, d, r, f, ce, q1, ed1, erv1, edr1, eov1, eun1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 0; clr_err = 0; wr_en = 0; rd_en = 0; data_in = '0;
    model_reset();
    #12;
    total++; if (v0 !== RESET_V) begin bad++; $display("FAIL reset_u0 got=%h exp=%h", v0, RESET_V); end
    total++; if (v1 !== RESET_V) begin bad++; $display("FAIL reset_u1 got=%h exp=%h", v1, RESET_V); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [7:0] x;
    for (int i = 0; i < D; i++) begin
      x = 8'(8'h11 * (i + 1));
      cyc(1, x, 0);
    end
    total++; if ({cnt0, full0, af0} !== {3'd5, 1'b1, 1'b1}) begin bad++;
      $display("FAIL fill_flags got=%0d/%b/%b exp=5/1/1", cnt0, full0, af0); end
    for (int i = 0; i < D; i++) begin
      x = 8'(8'h11 * (i + 1));
      cyc(0, 8'h00, 1);
      total++; if ({d0, rv0} !== {x, 1'b1}) begin bad++;
        $display("FAIL drain_u0[%0d] got=%h/%b exp=%h/1", i, d0, rv0, x); end
    end
    total++; if ({empty0, empty1} !== 2'b11) begin bad++;
      $display("FAIL drain_empty got=%b%b exp=11", empty0, empty1); end
  endtask

  task automatic test_wrap();
    logic [7:0] x;
    for (int i = 0; i < 3; i++) cyc(1, 8'($urandom), 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1);
    for (int i = 0; i < D; i++) begin
      x = 8'(8'hA0 + i);
      cyc(1, x, 0);
      total++; if (v0 !== exp_vec(q0.size(), ed0, erv0, eov0, eun0, edr0) || cnt0 > 3'd5) begin bad++;
        $display("FAIL wrap_wr[%0d] got=%h exp=%h", i, v0, exp_vec(q0.size(), ed0, erv0, eov0, eun0, edr0)); end
    end
    for (int i = 0; i < D; i++) begin
      x = 8'(8'hA0 + i);
      cyc(0, 8'h00, 1);
      total++; if ({d0, d1} !== {x, x}) begin bad++;
        $display("FAIL wrap_rd[%0d] got=%h,%h exp=%h", i, d0, d1, x); end
    end
  endtask

  task automatic test_full();
    for (int i = 1; i <= D; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'h06, 0);
    total++; if ({ovf0, cnt0, drp0} !== {1'b1, 3'd5, 1'b0}) begin bad++;
      $display("FAIL full_reject got=%b/%0d/%b exp=1/5/0", ovf0, cnt0, drp0); end
    total++; if ({ovf1, cnt1, drp1} !== {1'b0, 3'd5, 1'b1}) begin bad++;
      $display("FAIL full_overwrite got=%b/%0d/%b exp=0/5/1", ovf1, cnt1, drp1); end
    for (int i = 0; i < D; i++) begin
      cyc(0, 8'h00, 1);
      total++; if ({d0, d1} !== {8'(i + 1), 8'(i + 2)}) begin bad++;
        $display("FAIL full_rd[%0d] got=%h,%h exp=%h,%h", i, d0, d1, 8'(i + 1), 8'(i + 2)); end
      if (i == 0) begin
        total++; if (drp1 !== 1'b0) begin bad++; $display("FAIL drop_pulse got=%b exp=0", drp1); end
      end
    end
    cyc(0, 8'h00, 0, 0, 1);
    total++; if ({ovf0, unf0} !== 2'b00) begin bad++;
      $display("FAIL clr_err got=%b%b exp=00", ovf0, unf0); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= D; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'h99, 1);
    total++; if ({cnt0, cnt1, d0, d1, rv0, drp1, ovf0} !== {3'd5, 3'd5, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0}) begin bad++;
      $display("FAIL full_wr_rd got=%0d,%0d,%h,%h,%b,%b,%b exp=5,5,01,01,1,0,0", cnt0, cnt1, d0, d1, rv0, drp1, ovf0); end
    for (int i = 0; i < D; i++) begin
      cyc(0, 8'h00, 1);
      total++; if (v0 !== exp_vec(q0.size(), ed0, erv0, eov0, eun0, edr0)) begin bad++;
        $display("FAIL b2b_drain[%0d] got=%h exp=%h", i, v0, exp_vec(q0.size(), ed0, erv0, eov0, eun0, edr0)); end
    end
    cyc(1, 8'h7E, 1);
    total++; if ({unf0, rv0, cnt0, unf1, rv1, cnt1} !== {1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 3'd1}) begin bad++;
      $display("FAIL empty_wr_rd got=%b%b%0d %b%b%0d exp=101 101", unf0, rv0, cnt0, unf1, rv1, cnt1); end
    cyc(0, 8'h00, 1);
    total++; if ({d0, rv0, d1, rv1} !== {8'h7E, 1'b1, 8'h7E, 1'b1}) begin bad++;
      $display("FAIL empty_follow got=%h/%b %h/%b exp=7e/1", d0, rv0, d1, rv1); end
    cyc(0, 8'h00, 0, 0, 1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h30 + i), 0);
    cyc(1, 8'h55, 1, 1, 0);
    total++; if ({cnt0, empty0, ovf0, unf0, rv0, cnt1, empty1} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1}) begin bad++;
      $display("FAIL flush got=%0d%b%b%b%b %0d%b exp=01000 01", cnt0, empty0, ovf0, unf0, rv0, cnt1, empty1); end
    total++; if (v0 !== exp_vec(q0.size(), ed0, erv0, eov0, eun0, edr0)) begin bad++;
      $display("FAIL flush_vec got=%h exp=%h", v0, exp_vec(q0.size(), ed0, erv0, eov0, eun0, edr0)); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cyc($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
          $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
      total++; if (v0 !== exp_vec(q0.size(), ed0, erv0, eov0, eun0, edr0)) begin bad++;
        $display("FAIL rand_u0 cyc=%0d got=%h exp=%h", c, v0, exp_vec(q0.size(), ed0, erv0, eov0, eun0, edr0)); end
      total++; if (v1 !== exp_vec(q1.size(), ed1, erv1, eov1, eun1, edr1)) begin bad++;
        $display("FAIL rand_u1 cyc=%0d got=%h exp=%h", c, v1, exp_vec(q1.size(), ed1, erv1, eov1, eun1, edr1)); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'hC0 + i), 0);
    cyc(1, 8'hC8, 1);
    cyc(1, 8'hC9, 1, 0, 0);
    #2;
    rst = 1'b1; wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
    model_reset();
    #1;
    total++; if (v0 !== RESET_V) begin bad++; $display("FAIL async_rst_u0 got=%h exp=%h", v0, RESET_V); end
    total++; if (v1 !== RESET_V) begin bad++; $display("FAIL async_rst_u1 got=%h exp=%h", v1, RESET_V); end
    @(negedge clk); rst = 1'b0;
    cyc(1, 8'h3C, 0);
    cyc(0, 8'h00, 1);
    total++; if ({d0, rv0, cnt0, d1} !== {8'h3C, 1'b1, 3'd0, 8'h3C}) begin bad++;
      $display("FAIL post_rst got=%h/%b/%0d/%h exp=3c/1/0/3c", d0, rv0, cnt0, d1); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
